// File: rtl/jump_resolver.sv
// ----------------------------------------------------------------------------
// jump_resolver
//
// EX-stage resolution unit for the unconditional jump predictor. Each IF-stage
// prediction (taken flag plus predicted next PC) rides down the IF->ID->EX
// pipeline in two prediction slots alongside its instruction. In EX the
// prediction is compared with the resolved control-flow outcome. A mismatch
// does three things: it tells the predictor to update, it redirects the front
// end, and it flushes the two younger slots.
//
// Optional feature macro: JUMP_RESOLVER_STATS_EN
//   defined   -> saturating resolved/mispredict statistics counters
//   undefined -> counter logic absent, both count ports tied to 0
//
// Instruction class encoding on ir_type_in_ex:
//   JAL_IR = 4'd1, JALR_IR = 4'd2, BRANCH_IR = 4'd3, anything else = other
//
// Ports:
//   clk                    single clock, all state updates on posedge
//   rst                    synchronous active-high reset
//   valid_in_if            IF holds a real instruction this cycle
//   u_jump_in_if           predictor's taken decision for the IF instruction
//   addr_prediction_in_if  predictor's next PC for the IF instruction
//   stall                  pipeline hold for IF/ID/EX
//   pc4_in_ex              PC+4 of the EX instruction
//   ir_type_in_ex          instruction class of the EX instruction
//   branch_taken_in_ex     resolved branch condition (BRANCH_IR only)
//   target_addr_in_ex      computed jump/branch target
//   is_prediction_wrong    EX prediction mismatched the outcome (to predictor)
//   jump_addr_if_taken     copy of target_addr_in_ex (to predictor)
//   redirect               fetch from redirect_addr; also flushes IF and ID
//   redirect_addr          correct next PC of the EX instruction
//   resolved_count         valid control instructions resolved
//   mispredict_count       mispredictions seen
// ----------------------------------------------------------------------------
module jump_resolver #(
   parameter int COUNTER_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_in_if,
   input  logic                     u_jump_in_if,
   input  logic [31:0]              addr_prediction_in_if,
   input  logic                     stall,
   input  logic [31:0]              pc4_in_ex,
   input  logic [3:0]               ir_type_in_ex,
   input  logic                     branch_taken_in_ex,
   input  logic [31:0]              target_addr_in_ex,
   output logic                     is_prediction_wrong,
   output logic [31:0]              jump_addr_if_taken,
   output logic                     redirect,
   output logic [31:0]              redirect_addr,
   output logic [COUNTER_WIDTH-1:0] resolved_count,
   output logic [COUNTER_WIDTH-1:0] mispredict_count
);

   localparam logic [3:0] JAL_IR    = 4'd1;
   localparam logic [3:0] JALR_IR   = 4'd2;
   localparam logic [3:0] BRANCH_IR = 4'd3;

   logic        slot_id_valid;
   logic        slot_id_u_jump;
   logic [31:0] slot_id_addr;
   logic        slot_ex_valid;
   logic        slot_ex_u_jump;
   logic [31:0] slot_ex_addr;

   logic        is_ctrl;
   logic        actual_taken;
   logic [31:0] predicted_next;
   logic [31:0] actual_next;
   logic        wrong;

   // Resolve the EX prediction against the real outcome. A not-taken
   // prediction implies fall-through, so both sides reduce to a full next-PC
   // value and a single 32-bit compare catches wrong direction and wrong
   // target alike.
   always_comb begin
      is_ctrl      = 1'b0;
      actual_taken = 1'b0;
      case (ir_type_in_ex)
         JAL_IR, JALR_IR: begin
            is_ctrl      = 1'b1;
            actual_taken = 1'b1;
         end
         BRANCH_IR: begin
            is_ctrl      = 1'b1;
            actual_taken = branch_taken_in_ex;
         end
         default: begin
            is_ctrl      = 1'b0;
            actual_taken = 1'b0;
         end
      endcase
      predicted_next = slot_ex_u_jump ? slot_ex_addr : pc4_in_ex;
      actual_next    = actual_taken ? target_addr_in_ex : pc4_in_ex;
      wrong          = slot_ex_valid & is_ctrl & (predicted_next != actual_next);
   end

   // All outputs are held at zero while reset is asserted, which also
   // guarantees that reset beats a coincident misprediction.
   always_comb begin
      is_prediction_wrong = wrong & ~rst;
      redirect            = wrong & ~rst;
      redirect_addr       = rst ? 32'd0 : actual_next;
      jump_addr_if_taken  = rst ? 32'd0 : target_addr_in_ex;
   end

   // Prediction slots. A misprediction squashes both younger slots even
   // during a stall, because the instructions behind it are on the wrong
   // path and the front end is being redirected regardless.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_id_valid <= 1'b0;
         slot_ex_valid <= 1'b0;
      end else if (wrong) begin
         slot_id_valid <= 1'b0;
         slot_ex_valid <= 1'b0;
      end else if (!stall) begin
         slot_ex_valid  <= slot_id_valid;
         slot_ex_u_jump <= slot_id_u_jump;
         slot_ex_addr   <= slot_id_addr;
         slot_id_valid  <= valid_in_if;
         slot_id_u_jump <= u_jump_in_if;
         slot_id_addr   <= addr_prediction_in_if;
      end
   end

`ifdef JUMP_RESOLVER_STATS_EN
   logic [COUNTER_WIDTH-1:0] resolved_q;
   logic [COUNTER_WIDTH-1:0] mispredict_q;
   logic                     resolved_inc;

   // An instruction counts as resolved when it leaves EX; a misprediction
   // under stall still leaves EX because the slot is flushed.
   always_comb begin
      resolved_inc = slot_ex_valid & is_ctrl & (~stall | wrong);
   end

   // Saturating statistics counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         resolved_q   <= '0;
         mispredict_q <= '0;
      end else begin
         if (resolved_inc && (resolved_q != '1)) begin
            resolved_q <= resolved_q + COUNTER_WIDTH'(1);
         end
         if (wrong && (mispredict_q != '1)) begin
            mispredict_q <= mispredict_q + COUNTER_WIDTH'(1);
         end
      end
   end

   always_comb begin
      resolved_count   = rst ? '0 : resolved_q;
      mispredict_count = rst ? '0 : mispredict_q;
   end
`else
   always_comb begin
      resolved_count   = '0;
      mispredict_count = '0;
   end
`endif

endmodule

// File: tb/tb_jump_resolver.sv
// ----------------------------------------------------------------------------
// tb_jump_resolver
//
// Directed bench for jump_resolver built with COUNTER_WIDTH = 4. A table of
// per-cycle vectors walks through reset, correct and untrained jumps, a
// mispredicted branch, flush behaviour and stall interaction; hand-written
// sequences then cover counter saturation and reset beating a misprediction.
// Works with or without JUMP_RESOLVER_STATS_EN defined.
// ----------------------------------------------------------------------------
module tb_jump_resolver;

   localparam logic [3:0] OTH = 4'd0;
   localparam logic [3:0] JAL = 4'd1;
   localparam logic [3:0] JLR = 4'd2;
   localparam logic [3:0] BRA = 4'd3;

`ifdef JUMP_RESOLVER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      logic        rst;
      logic        valid;
      logic        uj;
      logic [31:0] ap;
      logic        stall;
      logic [31:0] pc4;
      logic [3:0]  ir;
      logic        bt;
      logic [31:0] tgt;
      logic        exp_wrong;
      logic [31:0] exp_jaddr;
      logic [31:0] exp_raddr;
      logic [3:0]  exp_res;
      logic [3:0]  exp_mis;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in_if;
   logic        u_jump_in_if;
   logic [31:0] addr_prediction_in_if;
   logic        stall;
   logic [31:0] pc4_in_ex;
   logic [3:0]  ir_type_in_ex;
   logic        branch_taken_in_ex;
   logic [31:0] target_addr_in_ex;
   logic        is_prediction_wrong;
   logic [31:0] jump_addr_if_taken;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic [3:0]  resolved_count;
   logic [3:0]  mispredict_count;

   int test_count = 0;
   int fail_count = 0;

   vec_t vecs[22];

   jump_resolver #(.COUNTER_WIDTH(4)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .valid_in_if           (valid_in_if),
      .u_jump_in_if          (u_jump_in_if),
      .addr_prediction_in_if (addr_prediction_in_if),
      .stall                 (stall),
      .pc4_in_ex             (pc4_in_ex),
      .ir_type_in_ex         (ir_type_in_ex),
      .branch_taken_in_ex    (branch_taken_in_ex),
      .target_addr_in_ex     (target_addr_in_ex),
      .is_prediction_wrong   (is_prediction_wrong),
      .jump_addr_if_taken    (jump_addr_if_taken),
      .redirect              (redirect),
      .redirect_addr         (redirect_addr),
      .resolved_count        (resolved_count),
      .mispredict_count      (mispredict_count)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic rst_v, input logic valid_v, input logic uj_v,
      input logic [31:0] ap_v, input logic stall_v, input logic [31:0] pc4_v,
      input logic [3:0] ir_v, input logic bt_v, input logic [31:0] tgt_v,
      input logic ew, input logic [31:0] ej, input logic [31:0] er,
      input logic [3:0] eres, input logic [3:0] emis);
      vec_t v;
      v.rst = rst_v;  v.valid = valid_v; v.uj = uj_v;   v.ap = ap_v;
      v.stall = stall_v; v.pc4 = pc4_v; v.ir = ir_v;    v.bt = bt_v;
      v.tgt = tgt_v;  v.exp_wrong = ew;  v.exp_jaddr = ej; v.exp_raddr = er;
      v.exp_res = eres; v.exp_mis = emis;
      return v;
   endfunction

   // Drives one cycle's worth of DUT inputs.
   task automatic applyStimulus(input vec_t v);
      rst                   = v.rst;
      valid_in_if           = v.valid;
      u_jump_in_if          = v.uj;
      addr_prediction_in_if = v.ap;
      stall                 = v.stall;
      pc4_in_ex             = v.pc4;
      ir_type_in_ex         = v.ir;
      branch_taken_in_ex    = v.bt;
      target_addr_in_ex     = v.tgt;
   endtask

   // Single comparison with pass/fail bookkeeping.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      test_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkAll(input string tag, input vec_t v);
      checkOutput({tag, " wrong"}, {31'd0, is_prediction_wrong}, {31'd0, v.exp_wrong});
      checkOutput({tag, " redirect"}, {31'd0, redirect}, {31'd0, v.exp_wrong});
      checkOutput({tag, " redirect_addr"}, redirect_addr, v.exp_raddr);
      checkOutput({tag, " jump_addr"}, jump_addr_if_taken, v.exp_jaddr);
      checkOutput({tag, " resolved_count"}, {28'd0, resolved_count},
                  STATS ? {28'd0, v.exp_res} : 32'd0);
      checkOutput({tag, " mispredict_count"}, {28'd0, mispredict_count},
                  STATS ? {28'd0, v.exp_mis} : 32'd0);
   endtask

   // Apply inputs, sample on negedge, then let the posedge consume them.
   task automatic runCycle(input string tag, input vec_t v);
      applyStimulus(v);
      @(negedge clk);
      checkAll(tag, v);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;
      int   redirect_seen;
      //             rst   vld   uj    ap            stl   pc4     ir   bt    tgt            wr    jaddr         raddr         res   mis
      vecs[0]  = mk(1'b1, 1'b1, 1'b1, 32'h999,  1'b0, 32'h10, JAL, 1'b0, 32'h300,  1'b0, 32'h0,    32'h0,    4'd0, 4'd0);
      vecs[1]  = mk(1'b1, 1'b1, 1'b1, 32'h999,  1'b0, 32'h10, JAL, 1'b0, 32'h300,  1'b0, 32'h0,    32'h0,    4'd0, 4'd0);
      vecs[2]  = mk(1'b0, 1'b1, 1'b1, 32'h100,  1'b0, 32'h0,  OTH, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0,    4'd0, 4'd0);
      vecs[3]  = mk(1'b0, 1'b1, 1'b0, 32'h48,   1'b0, 32'h0,  OTH, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0,    4'd0, 4'd0);
      vecs[4]  = mk(1'b0, 1'b1, 1'b1, 32'h700,  1'b0, 32'h8,  JAL, 1'b0, 32'h100,  1'b0, 32'h100,  32'h100,  4'd0, 4'd0);
      vecs[5]  = mk(1'b0, 1'b1, 1'b1, 32'h900,  1'b0, 32'h48, JAL, 1'b0, 32'h200,  1'b1, 32'h200,  32'h200,  4'd1, 4'd0);
      vecs[6]  = mk(1'b0, 1'b1, 1'b0, 32'h11,   1'b0, 32'h60, JAL, 1'b0, 32'h400,  1'b0, 32'h400,  32'h400,  4'd2, 4'd1);
      vecs[7]  = mk(1'b0, 1'b1, 1'b1, 32'h80,   1'b0, 32'h64, JAL, 1'b0, 32'h404,  1'b0, 32'h404,  32'h404,  4'd2, 4'd1);
      vecs[8]  = mk(1'b0, 1'b1, 1'b1, 32'h500,  1'b0, 32'h10, OTH, 1'b0, 32'h123,  1'b0, 32'h123,  32'h10,   4'd2, 4'd1);
      vecs[9]  = mk(1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h14, BRA, 1'b0, 32'h80,   1'b1, 32'h80,   32'h14,   4'd2, 4'd1);
      vecs[10] = mk(1'b0, 1'b1, 1'b1, 32'h240,  1'b0, 32'h0,  OTH, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0,    4'd3, 4'd2);
      vecs[11] = mk(1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,  OTH, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0,    4'd3, 4'd2);
      vecs[12] = mk(1'b0, 1'b1, 1'b1, 32'h333,  1'b0, 32'h30, JLR, 1'b0, 32'h240,  1'b0, 32'h240,  32'h240,  4'd3, 4'd2);
      vecs[13] = mk(1'b0, 1'b1, 1'b1, 32'h777,  1'b1, 32'h34, BRA, 1'b1, 32'h50,   1'b1, 32'h50,   32'h50,   4'd4, 4'd2);
      vecs[14] = mk(1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h34, BRA, 1'b1, 32'h50,   1'b0, 32'h50,   32'h50,   4'd5, 4'd3);
      vecs[15] = mk(1'b0, 1'b1, 1'b1, 32'h1000, 1'b0, 32'h38, JAL, 1'b0, 32'h90,   1'b0, 32'h90,   32'h90,   4'd5, 4'd3);
      vecs[16] = mk(1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h40, OTH, 1'b0, 32'h0,    1'b0, 32'h0,    32'h40,   4'd5, 4'd3);
      vecs[17] = mk(1'b0, 1'b1, 1'b1, 32'hdead, 1'b1, 32'h44, JAL, 1'b0, 32'h1000, 1'b0, 32'h1000, 32'h1000, 4'd5, 4'd3);
      vecs[18] = mk(1'b0, 1'b1, 1'b1, 32'hdead, 1'b1, 32'h44, JAL, 1'b0, 32'h1000, 1'b0, 32'h1000, 32'h1000, 4'd5, 4'd3);
      vecs[19] = mk(1'b0, 1'b1, 1'b1, 32'hdead, 1'b1, 32'h44, JAL, 1'b0, 32'h1000, 1'b0, 32'h1000, 32'h1000, 4'd5, 4'd3);
      vecs[20] = mk(1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h44, JAL, 1'b0, 32'h1000, 1'b0, 32'h1000, 32'h1000, 4'd5, 4'd3);
      vecs[21] = mk(1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,  OTH, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0,    4'd6, 4'd3);

      applyStimulus(vecs[0]);
      for (int i = 0; i < 22; i++) begin
         runCycle($sformatf("row%0d", i), vecs[i]);
      end

      // Saturation: an untrained JAL stream mispredicts every third cycle
      // (resolve, flush, refill), giving 20 mispredictions in 60 cycles.
      v = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h4, JAL, 1'b0, 32'h8,
             1'b0, 32'h0, 32'h0, 4'd0, 4'd0);
      runCycle("sat_rst0", v);
      runCycle("sat_rst1", v);
      v.rst = 1'b0;
      redirect_seen = 0;
      for (int k = 0; k < 60; k++) begin
         applyStimulus(v);
         @(negedge clk);
         checkOutput($sformatf("sat%0d redirect", k), {31'd0, redirect},
                     {31'd0, (k % 3) == 2});
         if (redirect) redirect_seen++;
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      checkOutput("sat redirect total", redirect_seen, 32'd20);
      checkOutput("sat resolved_count", {28'd0, resolved_count}, STATS ? 32'hF : 32'h0);
      checkOutput("sat mispredict_count", {28'd0, mispredict_count}, STATS ? 32'hF : 32'h0);
      @(posedge clk);
      #1;

      // Reset coinciding with a misprediction in EX: reset wins.
      v = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, OTH, 1'b0, 32'h0,
             1'b0, 32'h0, 32'h0, 4'd0, 4'd0);
      runCycle("rw_rst", v);
      v = mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, OTH, 1'b0, 32'h0,
             1'b0, 32'h0, 32'h0, 4'd0, 4'd0);
      runCycle("rw_fill", v);
      v.valid = 1'b0;
      runCycle("rw_wait", v);
      v = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h20, JAL, 1'b0, 32'h600,
             1'b0, 32'h0, 32'h0, 4'd0, 4'd0);
      runCycle("rw_collide", v);
      v = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h20, JAL, 1'b0, 32'h600,
             1'b0, 32'h600, 32'h600, 4'd0, 4'd0);
      runCycle("rw_after", v);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
